// File: rtl/load_issue_ctrl_pkg.sv
// Shared types for the load issue controller: queue entry, FSM state,
// ROB sizing and the wrap-aware "younger than branch" age test.
package load_issue_ctrl_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_AW    = $clog2(ROB_DEPTH);
  localparam int TAG_W     = 5;
  localparam int PREG_W    = 7;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  rob_tag;
    logic [PREG_W-1:0] pd;
    logic [31:0]       addr;
    logic [2:0]        func3;
  } ldq_entry_t;

  typedef enum logic {
    LD_IDLE,
    LD_BUSY
  } ld_state_t;

  // Distance from the branch, both measured mod ROB_DEPTH; the branch
  // itself lands at the top of the range and so is never younger.
  function automatic logic rob_is_younger(
    input logic [TAG_W-1:0] t,
    input logic [TAG_W-1:0] mp_tag,
    input logic [TAG_W-1:0] curr_tag
  );
    logic [ROB_AW-1:0] w_one;
    logic [ROB_AW-1:0] w_dt;
    logic [ROB_AW-1:0] w_dc;
    w_one = ROB_AW'(1);
    w_dt  = t[ROB_AW-1:0] - mp_tag[ROB_AW-1:0] - w_one;
    w_dc  = curr_tag[ROB_AW-1:0] - mp_tag[ROB_AW-1:0] - w_one;
    return w_dt < w_dc;
  endfunction

endpackage

// File: rtl/load_issue_ctrl_if.sv
// Bundle of RS request, memory, writeback, flush and status signals.
// master = RS/memory/ROB side, slave = load_issue_ctrl.
interface load_issue_ctrl_if #(
  parameter int DEPTH = 4
);
  import load_issue_ctrl_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [TAG_W-1:0]  in_rob_tag;
  logic [PREG_W-1:0] in_pd;
  logic [31:0]       in_addr;
  logic [2:0]        in_func3;
  logic              mem_issue;
  logic [31:0]       mem_addr;
  logic [2:0]        mem_func3;
  logic              mem_valid;
  logic [31:0]       mem_data;
  logic              done_valid;
  logic [TAG_W-1:0]  done_rob_tag;
  logic [PREG_W-1:0] done_pd;
  logic [31:0]       done_data;
  logic              mispredict;
  logic [TAG_W-1:0]  mispredict_tag;
  logic [TAG_W-1:0]  curr_rob_tag;
  logic              busy;
  logic [CW-1:0]     count;

  modport master (
    output in_valid, in_rob_tag, in_pd, in_addr, in_func3,
    output mem_valid, mem_data,
    output mispredict, mispredict_tag, curr_rob_tag,
    input  in_ready, mem_issue, mem_addr, mem_func3,
    input  done_valid, done_rob_tag, done_pd, done_data,
    input  busy, count
  );

  modport slave (
    input  in_valid, in_rob_tag, in_pd, in_addr, in_func3,
    input  mem_valid, mem_data,
    input  mispredict, mispredict_tag, curr_rob_tag,
    output in_ready, mem_issue, mem_addr, mem_func3,
    output done_valid, done_rob_tag, done_pd, done_data,
    output busy, count
  );

endinterface

// File: rtl/load_issue_ctrl_ldq.sv
// Circular load queue: storage, head/tail, flush invalidation, head skip.
// Ports: i_enq/i_in write at tail, i_pop/i_idle advance head, o_* status.
module load_issue_ctrl_ldq
  import load_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enq,
  input  ldq_entry_t       i_in,
  input  logic             i_flush,
  input  logic [TAG_W-1:0] i_mp_tag,
  input  logic [TAG_W-1:0] i_curr_tag,
  input  logic             i_idle,
  input  logic             i_pop,
  output logic             o_ready,
  output logic             o_alloc,
  output ldq_entry_t       o_head,
  output logic [CW-1:0]    o_count
);

  localparam logic [PW:0] P_ONE = (PW+1)'(1);

  ldq_entry_t  r_q [DEPTH];
  logic [PW:0] r_head;
  logic [PW:0] r_tail;

  logic [PW:0]   w_occ;
  logic [PW-1:0] w_hidx;
  logic [PW-1:0] w_tidx;
  logic          w_skip;
  logic          w_adv;

  // Pointers carry one extra bit so full and empty differ.
  assign w_occ   = r_tail - r_head;
  assign w_hidx  = r_head[PW-1:0];
  assign w_tidx  = r_tail[PW-1:0];
  assign o_alloc = (w_occ != '0);
  assign o_ready = (w_occ < CW'(DEPTH));
  assign o_head  = r_q[w_hidx];

  // Flushed slots stay allocated until head walks past them.
  assign w_skip = i_idle && o_alloc && !o_head.valid;
  assign w_adv  = w_skip || i_pop;

  always_comb begin
    o_count = '0;
    for (int i = 0; i < DEPTH; i++)
      o_count = o_count + CW'(r_q[i].valid);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_q[i] <= '0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_flush && r_q[i].valid &&
            rob_is_younger(r_q[i].rob_tag, i_mp_tag, i_curr_tag))
          r_q[i].valid <= 1'b0;
      if (i_pop)
        r_q[w_hidx].valid <= 1'b0;
      if (i_enq) begin
        r_q[w_tidx]       <= i_in;
        r_q[w_tidx].valid <= !(i_flush &&
          rob_is_younger(i_in.rob_tag, i_mp_tag, i_curr_tag));
        r_tail <= r_tail + P_ONE;
      end
      if (w_adv)
        r_head <= r_head + P_ONE;
    end
  end

endmodule

// File: rtl/load_issue_ctrl.sv
// Load issue controller: queues loads, issues one at a time, returns done.
// Ports: clk, reset, bus (slave) carrying request/memory/done/flush/status.
module load_issue_ctrl
  import load_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  load_issue_ctrl_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  ld_state_t         r_state;
  ld_state_t         w_state_n;
  logic [TAG_W-1:0]  r_if_tag;
  logic [PREG_W-1:0] r_if_pd;
  logic              r_kill;
  logic              r_done_valid;
  logic [TAG_W-1:0]  r_done_tag;
  logic [PREG_W-1:0] r_done_pd;
  logic [31:0]       r_done_data;

  ldq_entry_t        w_in;
  ldq_entry_t        w_head;
  logic              w_alloc;
  logic              w_ready;
  logic [CW-1:0]     w_count;
  logic              w_enq;
  logic              w_issue;
  logic              w_pop;
  logic              w_done_set;
  logic              w_head_fl;
  logic              w_if_fl;

  assign w_enq = bus.in_valid && w_ready;

  always_comb begin
    w_in         = '0;
    w_in.valid   = 1'b1;
    w_in.rob_tag = bus.in_rob_tag;
    w_in.pd      = bus.in_pd;
    w_in.addr    = bus.in_addr;
    w_in.func3   = bus.in_func3;
  end

  load_issue_ctrl_ldq #(
    .DEPTH(DEPTH)
  ) u_ldq (
    .clk       (clk),
    .reset     (reset),
    .i_enq     (w_enq),
    .i_in      (w_in),
    .i_flush   (bus.mispredict),
    .i_mp_tag  (bus.mispredict_tag),
    .i_curr_tag(bus.curr_rob_tag),
    .i_idle    (r_state == LD_IDLE),
    .i_pop     (w_pop),
    .o_ready   (w_ready),
    .o_alloc   (w_alloc),
    .o_head    (w_head),
    .o_count   (w_count)
  );

  assign w_head_fl = bus.mispredict &&
    rob_is_younger(w_head.rob_tag, bus.mispredict_tag, bus.curr_rob_tag);
  assign w_if_fl = bus.mispredict &&
    rob_is_younger(r_if_tag, bus.mispredict_tag, bus.curr_rob_tag);

  always_comb begin
    w_state_n  = r_state;
    w_issue    = 1'b0;
    w_pop      = 1'b0;
    w_done_set = 1'b0;
    unique case (r_state)
      LD_IDLE: begin
        // A head being flushed this cycle must not reach memory.
        if (w_alloc && w_head.valid && !w_head_fl) begin
          w_issue   = 1'b1;
          w_state_n = LD_BUSY;
        end
      end
      LD_BUSY: begin
        if (bus.mem_valid) begin
          w_pop      = 1'b1;
          w_done_set = !(r_kill || w_if_fl);
          w_state_n  = LD_IDLE;
        end
      end
      default: w_state_n = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= LD_IDLE;
      r_if_tag     <= '0;
      r_if_pd      <= '0;
      r_kill       <= 1'b0;
      r_done_valid <= 1'b0;
      r_done_tag   <= '0;
      r_done_pd    <= '0;
      r_done_data  <= '0;
    end else begin
      r_state      <= w_state_n;
      r_done_valid <= w_done_set;
      if (w_issue) begin
        r_if_tag <= w_head.rob_tag;
        r_if_pd  <= w_head.pd;
      end
      if (r_state == LD_BUSY) begin
        if (bus.mem_valid)
          r_kill <= 1'b0;
        else if (w_if_fl)
          r_kill <= 1'b1;
      end
      if (w_done_set) begin
        r_done_tag  <= r_if_tag;
        r_done_pd   <= r_if_pd;
        r_done_data <= bus.mem_data;
      end
    end
  end

  assign bus.in_ready     = w_ready;
  assign bus.mem_issue    = w_issue;
  assign bus.mem_addr     = w_head.addr;
  assign bus.mem_func3    = w_head.func3;
  assign bus.done_valid   = r_done_valid;
  assign bus.done_rob_tag = r_done_tag;
  assign bus.done_pd      = r_done_pd;
  assign bus.done_data    = r_done_data;
  assign bus.busy         = (r_state == LD_BUSY);
  assign bus.count        = w_count;

endmodule

// File: tb/tb_load_issue_ctrl.sv
// Self-checking bench for load_issue_ctrl: directed scenarios plus a
// randomized run against an in-order queue model of the load pipeline.
module tb_load_issue_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  load_issue_ctrl_if #(.DEPTH(4)) bus ();

  load_issue_ctrl #(.DEPTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  typedef struct {
    int          tag;
    int          pd;
    logic [31:0] addr;
    bit          alive;
  } mld_t;

  mld_t        q[$];
  bit          m_busy = 0;
  bit          m_dead = 0;
  int          m_tag = 0;
  int          m_pd = 0;
  int          m_lat = 0;
  bit          e_dv = 0;
  int          e_tag = 0;
  int          e_pd = 0;
  logic [31:0] e_data = '0;

  function automatic bit younger(int t, int mp, int cur);
    int a;
    int b;
    a = (t - mp - 1 + 32) % 16;
    b = (cur - mp - 1 + 32) % 16;
    return a < b;
  endfunction

  function automatic int alive_left();
    int n = 0;
    foreach (q[i]) if (q[i].alive) n++;
    return n;
  endfunction

  task automatic drive_idle();
    bus.in_valid = 0;
    bus.in_rob_tag = '0;
    bus.in_pd = '0;
    bus.in_addr = '0;
    bus.in_func3 = '0;
    bus.mem_valid = 0;
    bus.mem_data = '0;
    bus.mispredict = 0;
    bus.mispredict_tag = '0;
    bus.curr_rob_tag = '0;
  endtask

  task automatic enq(input int tag, input int pd, input logic [31:0] a);
    drive_idle();
    bus.in_valid = 1;
    bus.in_rob_tag = 5'(tag);
    bus.in_pd = 7'(pd);
    bus.in_addr = a;
    bus.in_func3 = 3'd2;
  endtask

  task automatic settle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_idle();
    end
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.mem_issue !== 1'b0 ||
        bus.busy !== 1'b0 || bus.count !== 3'd0 ||
        bus.done_valid !== 1'b0 || bus.done_data !== 32'h0 ||
        bus.done_rob_tag !== 5'd0 || bus.done_pd !== 7'd0) begin
      errs++;
      $display("FAIL reset_state: rdy=%b iss=%b busy=%b cnt=%0d dv=%b want 1 0 0 0 0",
               bus.in_ready, bus.mem_issue, bus.busy, bus.count, bus.done_valid);
    end
    @(negedge clk);
    reset = 0;
    settle(1);
  endtask

  task automatic test_single();
    @(negedge clk);
    enq(3, 12, 32'h10);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errs++; $display("FAIL single_ready: got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (bus.mem_issue !== 1'b1 || bus.mem_addr !== 32'h10) begin
      errs++;
      $display("FAIL single_issue: iss=%b addr=%h want 1 10", bus.mem_issue, bus.mem_addr);
    end
    @(negedge clk);
    bus.mem_valid = 1;
    bus.mem_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.mem_issue !== 1'b0 || bus.done_valid !== 1'b0) begin
      errs++;
      $display("FAIL single_busy: busy=%b iss=%b dv=%b want 1 0 0",
               bus.busy, bus.mem_issue, bus.done_valid);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (bus.done_valid !== 1'b1 || bus.done_rob_tag !== 5'd3 ||
        bus.done_pd !== 7'd12 || bus.done_data !== 32'hDEADBEEF ||
        bus.count !== 3'd0) begin
      errs++;
      $display("FAIL single_done: dv=%b tag=%0d pd=%0d data=%h cnt=%0d want 1 3 12 deadbeef 0",
               bus.done_valid, bus.done_rob_tag, bus.done_pd, bus.done_data, bus.count);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.done_valid !== 1'b0 || bus.done_data !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL single_pulse: dv=%b data=%h want 0 deadbeef", bus.done_valid, bus.done_data);
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      enq(k, 20 + k, 32'h100 + 32'(4 * k));
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errs++; $display("FAIL fill_ready_%0d: got %b want 1", k, bus.in_ready);
      end
      if (k == 1) begin
        checks++;
        if (bus.mem_issue !== 1'b1 || bus.mem_addr !== 32'h100) begin
          errs++;
          $display("FAIL fill_issue0: iss=%b addr=%h want 1 100", bus.mem_issue, bus.mem_addr);
        end
      end
    end
    @(negedge clk);
    enq(9, 99, 32'h999);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.count !== 3'd4) begin
      errs++;
      $display("FAIL fill_full: rdy=%b cnt=%0d want 0 4", bus.in_ready, bus.count);
    end
    @(negedge clk);
    drive_idle();
    bus.mem_valid = 1;
    bus.mem_data = 32'hA000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_idle();
      #1;
      checks++;
      if (bus.done_valid !== 1'b1 || bus.done_rob_tag !== 5'(k) ||
          bus.done_pd !== 7'(20 + k) || bus.done_data !== 32'hA000 + 32'(k)) begin
        errs++;
        $display("FAIL fill_done_%0d: dv=%b tag=%0d data=%h want 1 %0d %h", k,
                 bus.done_valid, bus.done_rob_tag, bus.done_data, k, 32'hA000 + k);
      end
      if (k == 0) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errs++; $display("FAIL fill_ready_rise: got %b want 1", bus.in_ready);
        end
      end
      checks++;
      if (k < 3) begin
        if (bus.mem_issue !== 1'b1 || bus.mem_addr !== 32'h100 + 32'(4 * (k + 1))) begin
          errs++;
          $display("FAIL fill_issue_%0d: iss=%b addr=%h want 1 %h", k + 1,
                   bus.mem_issue, bus.mem_addr, 32'h100 + 4 * (k + 1));
        end
        @(negedge clk);
        bus.mem_valid = 1;
        bus.mem_data = 32'hA000 + 32'(k + 1);
      end else if (bus.mem_issue !== 1'b0 || bus.count !== 3'd0) begin
        errs++;
        $display("FAIL fill_end: iss=%b cnt=%0d want 0 0", bus.mem_issue, bus.count);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.done_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL fill_no_fifth: dv=%b busy=%b want 0 0", bus.done_valid, bus.busy);
    end
  endtask

  task automatic test_queue_flush();
    @(negedge clk); enq(2, 30, 32'h200);
    @(negedge clk); enq(5, 31, 32'h204);
    @(negedge clk); enq(7, 32, 32'h208);
    @(negedge clk);
    drive_idle();
    bus.mispredict = 1;
    bus.mispredict_tag = 5'd4;
    bus.curr_rob_tag = 5'd8;
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.count !== 3'd3) begin
      errs++;
      $display("FAIL qflush_pre: busy=%b cnt=%0d want 1 3", bus.busy, bus.count);
    end
    @(negedge clk);
    drive_idle();
    bus.mem_valid = 1;
    bus.mem_data = 32'h1234;
    #1;
    checks++;
    if (bus.count !== 3'd1) begin
      errs++; $display("FAIL qflush_count: got %0d want 1", bus.count);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (bus.done_valid !== 1'b1 || bus.done_rob_tag !== 5'd2 || bus.done_data !== 32'h1234) begin
      errs++;
      $display("FAIL qflush_done: dv=%b tag=%0d data=%h want 1 2 1234",
               bus.done_valid, bus.done_rob_tag, bus.done_data);
    end
    repeat (4) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.mem_issue !== 1'b0 || bus.done_valid !== 1'b0 || bus.count !== 3'd0) begin
        errs++;
        $display("FAIL qflush_skip: iss=%b dv=%b cnt=%0d want 0 0 0",
                 bus.mem_issue, bus.done_valid, bus.count);
      end
    end
  endtask

  task automatic test_inflight_kill();
    @(negedge clk); enq(6, 40, 32'h300);
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (bus.mem_issue !== 1'b1 || bus.mem_addr !== 32'h300) begin
      errs++;
      $display("FAIL kill_issue: iss=%b addr=%h want 1 300", bus.mem_issue, bus.mem_addr);
    end
    @(negedge clk);
    bus.mispredict = 1;
    bus.mispredict_tag = 5'd5;
    bus.curr_rob_tag = 5'd9;
    @(negedge clk);
    drive_idle();
    bus.mem_valid = 1;
    bus.mem_data = 32'h5555;
    #1;
    checks++;
    if (bus.count !== 3'd0 || bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL kill_count: cnt=%0d busy=%b want 0 1", bus.count, bus.busy);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (bus.done_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL kill_no_done: dv=%b busy=%b want 0 0", bus.done_valid, bus.busy);
    end
    settle(2);
  endtask

  task automatic test_wrap();
    @(negedge clk); enq(13, 50, 32'h400);
    @(negedge clk); enq(14, 51, 32'h404);
    @(negedge clk); enq(0, 52, 32'h408);
    @(negedge clk);
    drive_idle();
    bus.mispredict = 1;
    bus.mispredict_tag = 5'd15;
    bus.curr_rob_tag = 5'd2;
    @(negedge clk);
    drive_idle();
    bus.mem_valid = 1;
    bus.mem_data = 32'hAA;
    #1;
    checks++;
    if (bus.count !== 3'd2) begin
      errs++; $display("FAIL wrap_count: got %0d want 2", bus.count);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (bus.done_valid !== 1'b1 || bus.done_rob_tag !== 5'd13 ||
        bus.mem_issue !== 1'b1 || bus.mem_addr !== 32'h404) begin
      errs++;
      $display("FAIL wrap_first: dv=%b tag=%0d iss=%b addr=%h want 1 13 1 404",
               bus.done_valid, bus.done_rob_tag, bus.mem_issue, bus.mem_addr);
    end
    @(negedge clk);
    bus.mem_valid = 1;
    bus.mem_data = 32'hBB;
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (bus.done_valid !== 1'b1 || bus.done_rob_tag !== 5'd14 ||
        bus.done_pd !== 7'd51 || bus.mem_issue !== 1'b0) begin
      errs++;
      $display("FAIL wrap_second: dv=%b tag=%0d pd=%0d iss=%b want 1 14 51 0",
               bus.done_valid, bus.done_rob_tag, bus.done_pd, bus.mem_issue);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.mem_issue !== 1'b0 || bus.count !== 3'd0 || bus.done_valid !== 1'b0) begin
        errs++;
        $display("FAIL wrap_tail: iss=%b cnt=%0d dv=%b want 0 0 0",
                 bus.mem_issue, bus.count, bus.done_valid);
      end
    end
  endtask

  task automatic test_no_flush_edge();
    @(negedge clk); enq(1, 60, 32'h500);
    @(negedge clk); enq(5, 61, 32'h504);
    @(negedge clk); enq(9, 62, 32'h508);
    @(negedge clk);
    drive_idle();
    bus.mispredict = 1;
    bus.mispredict_tag = 5'd3;
    bus.curr_rob_tag = 5'd4;
    @(negedge clk);
    drive_idle();
    bus.mem_valid = 1;
    bus.mem_data = 32'h11;
    #1;
    checks++;
    if (bus.count !== 3'd3) begin
      errs++; $display("FAIL noflush_count: got %0d want 3", bus.count);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_idle();
      #1;
      checks++;
      if (bus.done_valid !== 1'b1 || bus.done_rob_tag !== 5'(1 + 4 * k) ||
          bus.done_data !== 32'h11 + 32'(k)) begin
        errs++;
        $display("FAIL noflush_done_%0d: dv=%b tag=%0d data=%h want 1 %0d %h", k,
                 bus.done_valid, bus.done_rob_tag, bus.done_data, 1 + 4 * k, 32'h11 + k);
      end
      if (k < 2) begin
        @(negedge clk);
        bus.mem_valid = 1;
        bus.mem_data = 32'h11 + 32'(k + 1);
      end
    end
    settle(2);
  endtask

  task automatic rand_cycle(input bit gen);
    bit issued;
    int it;
    int imp;
    int icur;
    @(negedge clk);
    drive_idle();
    if (gen) begin
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_rob_tag = 5'($urandom_range(0, 15));
      bus.in_pd = 7'($urandom_range(0, 127));
      bus.in_addr = $urandom;
      bus.in_func3 = 3'($urandom_range(0, 7));
      bus.mispredict = ($urandom_range(0, 7) == 0);
      bus.mispredict_tag = 5'($urandom_range(0, 15));
      bus.curr_rob_tag = 5'($urandom_range(0, 15));
    end
    bus.mem_valid = m_busy && (m_lat == 0);
    bus.mem_data = $urandom;
    #1;
    imp = int'(bus.mispredict_tag);
    icur = int'(bus.curr_rob_tag);
    checks++;
    if (bus.done_valid !== e_dv) begin
      errs++; $display("FAIL rnd_done_valid: got %b want %b", bus.done_valid, e_dv);
    end else if (e_dv) begin
      checks++;
      if (bus.done_rob_tag !== 5'(e_tag) || bus.done_pd !== 7'(e_pd) ||
          bus.done_data !== e_data) begin
        errs++;
        $display("FAIL rnd_done_fields: tag=%0d pd=%0d data=%h want %0d %0d %h",
                 bus.done_rob_tag, bus.done_pd, bus.done_data, e_tag, e_pd, e_data);
      end
    end
    checks++;
    if (bus.busy !== m_busy || bus.count !== 3'(alive_left() + ((m_busy && !m_dead) ? 1 : 0))) begin
      errs++;
      $display("FAIL rnd_status: busy=%b cnt=%0d want %b %0d", bus.busy, bus.count,
               m_busy, alive_left() + ((m_busy && !m_dead) ? 1 : 0));
    end
    issued = 0;
    if (bus.mem_issue) begin
      while (q.size() > 0 && !q[0].alive) void'(q.pop_front());
      checks++;
      if (m_busy || q.size() == 0) begin
        errs++;
        $display("FAIL rnd_issue_state: busy_model=%b pending=%0d want 0 >0", m_busy, q.size());
      end else begin
        if (bus.mem_addr !== q[0].addr ||
            (bus.mispredict && younger(q[0].tag, imp, icur))) begin
          errs++;
          $display("FAIL rnd_issue_addr: addr=%h want %h", bus.mem_addr, q[0].addr);
        end
        m_busy = 1;
        m_dead = 0;
        m_tag = q[0].tag;
        m_pd = q[0].pd;
        m_lat = $urandom_range(0, 2);
        void'(q.pop_front());
        issued = 1;
      end
    end
    if (bus.mispredict) begin
      foreach (q[i]) if (younger(q[i].tag, imp, icur)) q[i].alive = 0;
      if (m_busy && !issued && younger(m_tag, imp, icur)) m_dead = 1;
    end
    e_dv = 0;
    if (bus.mem_valid) begin
      if (!m_dead) begin
        e_dv = 1;
        e_tag = m_tag;
        e_pd = m_pd;
        e_data = bus.mem_data;
      end
      m_busy = 0;
    end else if (m_busy && !issued && m_lat > 0) begin
      m_lat--;
    end
    if (bus.in_valid && bus.in_ready) begin
      it = int'(bus.in_rob_tag);
      q.push_back('{tag: it, pd: int'(bus.in_pd), addr: bus.in_addr,
                    alive: !(bus.mispredict && younger(it, imp, icur))});
    end
  endtask

  task automatic test_random();
    int guard;
    q.delete();
    m_busy = 0;
    m_dead = 0;
    e_dv = 0;
    repeat (600) rand_cycle(1);
    guard = 0;
    while ((alive_left() > 0 || m_busy || e_dv) && guard < 100) begin
      rand_cycle(0);
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errs++;
      $display("FAIL rnd_drain: left=%0d busy=%b want 0 0", alive_left(), m_busy);
    end
    settle(6);
    #1;
    checks++;
    if (bus.count !== 3'd0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL rnd_final: cnt=%0d rdy=%b busy=%b want 0 1 0",
               bus.count, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); enq(1, 70, 32'h600);
    @(negedge clk); enq(2, 71, 32'h604);
    @(negedge clk); enq(3, 72, 32'h608);
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.count !== 3'd3) begin
      errs++;
      $display("FAIL areset_pre: busy=%b cnt=%0d want 1 3", bus.busy, bus.count);
    end
    #1;
    reset = 1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.count !== 3'd0 || bus.in_ready !== 1'b1 ||
        bus.mem_issue !== 1'b0 || bus.done_valid !== 1'b0 ||
        bus.done_rob_tag !== 5'd0 || bus.done_pd !== 7'd0 || bus.done_data !== 32'h0) begin
      errs++;
      $display("FAIL areset_clear: busy=%b cnt=%0d rdy=%b tag=%0d data=%h want 0 0 1 0 0",
               bus.busy, bus.count, bus.in_ready, bus.done_rob_tag, bus.done_data);
    end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    bus.mem_valid = 1;
    bus.mem_data = 32'hBAD;
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (bus.done_valid !== 1'b0 || bus.busy !== 1'b0 || bus.count !== 3'd0) begin
      errs++;
      $display("FAIL areset_stray: dv=%b busy=%b cnt=%0d want 0 0 0",
               bus.done_valid, bus.busy, bus.count);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single();
    settle(1);
    test_fill();
    settle(1);
    test_queue_flush();
    test_inflight_kill();
    test_wrap();
    test_no_flush_edge();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/load_issue_ctrl.md
Name: load_issue_ctrl

Overview:
- Sequences the load datapath: buffers load requests from the memory RS in a small circular queue and issues one load at a time to the data memory.
- Tracks the single in-flight access and returns the completion (rob tag, pd, data) toward the PRF/ROB writeback.
- On a branch mispredict, squashes queued and in-flight loads that are younger than the mispredicting branch.

Parameters:
- DEPTH, 4, number of queue entries (power of 2, at least 2)
- PREG_W, 7, physical register index width
- ROB_DEPTH, 16, ROB entries; tags are in 0..ROB_DEPTH-1 and carried on 5 bits

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  RS presents an address-resolved load
- in_ready  out  1  queue can accept this cycle
- in_rob_tag  in  5  ROB index of load
- in_pd  in  PREG_W  destination physical register
- in_addr  in  32  effective address (ps1 + imm)
- in_func3  in  3  load width/sign code
- mem_issue  out  1  single-cycle strobe starting a memory read
- mem_addr  out  32  address for issued read
- mem_func3  out  3  func3 for issued read
- mem_valid  in  1  memory read data valid
- mem_data  in  32  memory read data
- done_valid  out  1  completion valid (one cycle)
- done_rob_tag  out  5  completing ROB index
- done_pd  out  PREG_W  completing pd
- done_data  out  32  load result
- mispredict  in  1  flush request
- mispredict_tag  in  5  ROB tag of mispredicting branch
- curr_rob_tag  in  5  ROB allocation pointer (next free tag)
- busy  out  1  state is BUSY
- count  out  $clog2(DEPTH)+1  valid entries held

Behaviour:
- Reset (async): all entry valid bits 0, head=tail=0, state IDLE, inflight_kill 0. Outputs: done_valid 0, done_rob_tag 0, done_pd 0, done_data 0, mem_issue 0, busy 0, count 0, in_ready 1.
- Entry fields: valid, rob_tag, pd, addr, func3. Slots are allocated at tail in arrival order.
- Enqueue: on in_valid & in_ready, write the slot at tail, tail++ mod DEPTH. in_ready = (slots between head and tail) < DEPTH. A slot is freed only when head advances; there is no same-cycle bypass when full.
- Younger test, all mod ROB_DEPTH: tag t is younger iff (t - mispredict_tag - 1) < (curr_rob_tag - mispredict_tag - 1). The branch's own tag is never younger. If curr_rob_tag == mispredict_tag+1, nothing is younger.
- Flush: while mispredict=1, clear valid on every younger entry in that cycle. A same-cycle incoming load that is younger is accepted but written invalid; tail still advances.
- Head skip: in IDLE, if the head slot is allocated but invalid, head++ (one slot per cycle) without issuing.
- FSM IDLE: if the head slot is valid and not being flushed this cycle:
  - mem_issue=1 combinationally, with mem_addr/mem_func3 taken from the head entry;
  - latch inflight rob_tag/pd;
  - go to BUSY next cycle.
- FSM BUSY: mem_issue=0, busy=1. If mispredict marks the in-flight tag younger, set inflight_kill. On mem_valid:
  - head++ and clear that slot's valid;
  - if not killed and not flushed in this same cycle, register done_valid=1 with done_rob_tag/pd/data next cycle;
  - clear inflight_kill and return to IDLE.
  - A back-to-back issue from IDLE happens the cycle after mem_valid at the earliest.
- mem_valid in IDLE is ignored.
- done_valid is a 1-cycle pulse; the other done fields hold their last value.
- Issue-to-done latency: memory latency L plus 1 cycle. With L=1, issue at cycle N gives done_valid at N+2.
- count = number of valid entries, including the in-flight entry until its mem_valid.
- Reset mid-operation: immediate clear. A late mem_valid after reset is ignored (state is IDLE).

Decomposition:
- Shared package (types_pkg):
  - ldq_entry_t struct (valid, rob_tag, pd, addr, func3);
  - ld_state_t enum {LD_IDLE, LD_BUSY};
  - ROB_DEPTH constant;
  - function rob_is_younger(t, mp_tag, curr_tag).
- One natural sub-module: ldq_buffer (storage, head/tail pointers, flush invalidation, head skip). The FSM and completion register live in the top.

Test Plan:
- Single load: enqueue tag 3, pd 12, addr 0x10; memory returns 0xDEADBEEF 1 cycle after mem_issue -> mem_issue at cycle 1, done_valid at cycle 3 with tag 3 / pd 12 / data 0xDEADBEEF; count returns to 0.
- Fill: 4 loads back-to-back, memory stalled -> in_ready=0 after the 4th; 5th in_valid is not accepted; completions drain in order 0,1,2,3 and in_ready rises after the first mem_valid.
- Queue flush: queued tags 2,5,7, in flight 2, mispredict_tag 4, curr_rob_tag 8 -> 5 and 7 invalidated and skipped, only tag 2 completes, count ends 0.
- In-flight kill: tag 6 in flight, mispredict_tag 5, curr_rob_tag 9 -> mem_valid produces no done_valid; FSM returns to IDLE.
- Wrap/edge: mispredict_tag 15, curr_rob_tag 2, queued tags 0 and 14 -> 0 flushed, 14 kept. Separately, mispredict_tag 3 with curr_rob_tag 4 -> nothing flushed.
- Async reset while BUSY with 3 entries -> all outputs 0 and count 0 before the next clock edge; a subsequent stray mem_valid yields no done_valid.
